// File: rtl/mod_round_mux_2to1_if.sv
// Handshake bundle for the AES round-state merge mux: fresh block (in0),
// round feedback (in1) and the registered, round-tagged output.
interface mod_round_mux_2to1_if #(
    parameter int N      = 16,
    parameter int ADDR_W = 4
);
    logic                  in0_valid;
    logic                  in0_ready;
    logic [N-1:0][7:0]     in0_data;

    logic                  in1_valid;
    logic                  in1_ready;
    logic [N-1:0][7:0]     in1_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0][7:0]     out_data;
    logic [ADDR_W-1:0]     out_addr;

    logic                  busy;

    // Design-side view.
    modport slave (
        input  in0_valid, in0_data,
        input  in1_valid, in1_data,
        input  out_ready,
        output in0_ready, in1_ready,
        output out_valid, out_data, out_addr,
        output busy
    );

    // Environment-side view.
    modport master (
        output in0_valid, in0_data,
        output in1_valid, in1_data,
        output out_ready,
        input  in0_ready, in1_ready,
        input  out_valid, out_data, out_addr,
        input  busy
    );
endinterface

// File: rtl/mod_round_mux_2to1.sv
// Round-state merge mux: picks a fresh block or the round feedback, registers
// it and tags it with the round index consumed by the downstream demux.
module mod_round_mux_2to1 #(
    parameter int N       = 16,
    parameter int NROUNDS = 14,
    parameter int ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mod_round_mux_2to1_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NROUNDS);

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [N-1:0][7:0]   out_data_q, out_data_d;

    logic                load_ok;
    logic                out_hs;
    logic                in0_rdy;
    logic                in1_rdy;
    logic                load_in0;
    logic                load_in1;
    logic [ADDR_W-1:0]   addr_inc;
    state_t              state_after_first;

    // Single output register, no skid: refill allowed whenever it empties this cycle.
    assign load_ok  = !out_valid_q || bus.out_ready;
    assign out_hs   = out_valid_q && bus.out_ready;
    assign addr_inc = out_addr_q + ADDR_W'(1);

    // A one-round configuration issues its final round straight from the fresh block.
    assign state_after_first = (ADDR_FIRST == ADDR_LAST) ? ST_DRAIN : ST_ROUND;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        in0_rdy     = 1'b0;
        in1_rdy     = 1'b0;
        load_in0    = 1'b0;
        load_in1    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in0_rdy = load_ok && !rst;
                if (bus.in0_valid && in0_rdy) begin
                    load_in0    = 1'b1;
                    out_valid_d = 1'b1;
                    out_addr_d  = ADDR_FIRST;
                    state_d     = state_after_first;
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                end
            end

            ST_ROUND: begin
                in1_rdy = load_ok && !rst;
                if (bus.in1_valid && in1_rdy) begin
                    load_in1    = 1'b1;
                    out_valid_d = 1'b1;
                    out_addr_d  = addr_inc;
                    if (addr_inc == ADDR_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                end
            end

            ST_DRAIN: begin
                // Next block may only enter as the final round leaves.
                in0_rdy = bus.out_ready && !rst;
                if (out_hs) begin
                    if (bus.in0_valid && in0_rdy) begin
                        load_in0    = 1'b1;
                        out_valid_d = 1'b1;
                        out_addr_d  = ADDR_FIRST;
                        state_d     = state_after_first;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_byte
            assign out_data_d[gi] = load_in0 ? bus.in0_data[gi] :
                                    load_in1 ? bus.in1_data[gi] :
                                               out_data_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in0_ready = in0_rdy;
    assign bus.in1_ready = in1_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod_round_mux_2to1.sv
// Directed bench for the round-state merge mux: reset, full block walk,
// backpressure, back-to-back ordering, mid-block reset and idle-time in1.
module tb_mod_round_mux_2to1;

    localparam int N       = 16;
    localparam int NROUNDS = 14;
    localparam int ADDR_W  = 4;

    localparam logic [127:0] D0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D1 = 128'h11223344556677889900aabbccddeeff;
    localparam logic [127:0] D2 = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] D3 = 128'h5a5a5a5aa5a5a5a53c3c3c3cc3c3c3c3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   in1_acc;

    mod_round_mux_2to1_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    mod_round_mux_2to1 #(
        .N       (N),
        .NROUNDS (NROUNDS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks issued rounds first..last of a block whose round-1 state is base;
    // feedback for round a is base+a. Returns with the last round's inputs driven.
    task automatic walk(input logic [127:0] base, input int first, input int last,
                        input int stall_at, input bit in0_hold);
        for (int a = first; a <= last; a++) begin
            chk($sformatf("addr_r%0d", a), 128'(bus.out_addr), 128'(a));
            chk($sformatf("data_r%0d", a), 128'(bus.out_data), base + 128'(a - 1));
            chk($sformatf("valid_r%0d", a), 128'(bus.out_valid), 128'd1);
            chk($sformatf("busy_r%0d", a), 128'(bus.busy), 128'd1);
            if (a == stall_at) begin
                bus.out_ready = 1'b0;
                bus.in1_valid = 1'b1;
                bus.in1_data  = base + 128'(a);
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk($sformatf("stall%0d_in1_ready", s), 128'(bus.in1_ready), 128'd0);
                    tick();
                    chk($sformatf("stall%0d_addr", s), 128'(bus.out_addr), 128'(a));
                    chk($sformatf("stall%0d_data", s), 128'(bus.out_data), base + 128'(a - 1));
                end
                bus.out_ready = 1'b1;
            end
            if (a < NROUNDS) begin
                bus.in1_valid = 1'b1;
                bus.in1_data  = base + 128'(a);
                #1;
                chk($sformatf("in1_ready_r%0d", a), 128'(bus.in1_ready), 128'd1);
                if (bus.in1_ready) in1_acc++;
                if (in0_hold) chk($sformatf("in0_ready_r%0d", a), 128'(bus.in0_ready), 128'd0);
            end else begin
                bus.in1_valid = 1'b0;
                #1;
                chk("in1_ready_drain", 128'(bus.in1_ready), 128'd0);
                chk("in0_ready_drain", 128'(bus.in0_ready), 128'd1);
            end
            if (a < last) tick();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        in1_acc       = 0;
        rst           = 1'b1;
        bus.in0_valid = 1'b1;
        bus.in0_data  = D0;
        bus.in1_valid = 1'b0;
        bus.in1_data  = '0;
        bus.out_ready = 1'b1;

        // Reset held two cycles with a fresh block offered.
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
            chk("rst_out_data", 128'(bus.out_data), 128'd0);
            chk("rst_out_addr", 128'(bus.out_addr), 128'd0);
            chk("rst_busy", 128'(bus.busy), 128'd0);
            chk("rst_in0_ready", 128'(bus.in0_ready), 128'd0);
        end
        rst = 1'b0;
        #1;
        chk("idle_in0_ready", 128'(bus.in0_ready), 128'd1);
        chk("idle_in1_ready", 128'(bus.in1_ready), 128'd0);

        // Block 1: straight walk with out_ready high.
        tick();
        bus.in0_valid = 1'b0;
        walk(D0, 1, NROUNDS, 0, 1'b0);
        tick();
        chk("b1_done_busy", 128'(bus.busy), 128'd0);
        chk("b1_done_valid", 128'(bus.out_valid), 128'd0);
        chk("b1_done_in0_ready", 128'(bus.in0_ready), 128'd1);
        chk("b1_done_in1_ready", 128'(bus.in1_ready), 128'd0);
        chk("b1_in1_accepts", 128'(in1_acc), 128'd13);

        // Block 2: in0 held valid throughout, stall at round 5.
        bus.in0_valid = 1'b1;
        bus.in0_data  = D1;
        tick();
        bus.in0_data  = D2;
        walk(D1, 1, NROUNDS, 5, 1'b1);
        tick();
        bus.in0_valid = 1'b0;
        chk("b2b_addr", 128'(bus.out_addr), 128'd1);
        chk("b2b_data", 128'(bus.out_data), D2);
        chk("b2b_valid", 128'(bus.out_valid), 128'd1);

        // Block 3: reset lands at round 7.
        walk(D2, 1, 7, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_addr", 128'(bus.out_addr), 128'd0);
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        chk("midrst_data", 128'(bus.out_data), 128'd0);

        // Feedback offered while idle is never taken.
        bus.in1_valid = 1'b1;
        bus.in1_data  = D3;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("idle_in1_%0d_ready", c), 128'(bus.in1_ready), 128'd0);
            tick();
            chk($sformatf("idle_in1_%0d_valid", c), 128'(bus.out_valid), 128'd0);
        end
        bus.in1_valid = 1'b0;

        bus.in0_valid = 1'b1;
        bus.in0_data  = D3;
        tick();
        bus.in0_valid = 1'b0;
        chk("restart_addr", 128'(bus.out_addr), 128'd1);
        chk("restart_data", 128'(bus.out_data), D3);
        chk("restart_busy", 128'(bus.busy), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
